// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM state
// encoding, opcode values, AluOp codes (shared with AluControl) and ImmSrc codes.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXE_R   = 4'd6,
    ST_EXE_I   = 4'd7,
    ST_ALU_WB  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JAL     = 4'd10,
    ST_JALR    = 4'd11,
    ST_JALR_PC = 4'd12,
    ST_LUI     = 4'd13,
    ST_HALT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multi_cycle_controller_imm_src_decoder.sv
// Combinational opcode -> immediate format select. Opcodes without an
// immediate (R-type, unknown) fall back to the I format.
module imm_src_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src
);

  // Map each opcode to the immediate layout its encoding uses.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: imm_src = IMM_I;
      OP_STORE:               imm_src = IMM_S;
      OP_BRANCH:              imm_src = IMM_B;
      OP_JAL:                 imm_src = IMM_J;
      OP_LUI:                 imm_src = IMM_U;
      default:                imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback, drives datapath enables
// and mux selects, and resolves branches from the ALU flags.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] imm_src_s;
  logic       taken_s;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src_s)
  );

  // State register; reset forces a clean restart from FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Branch condition from func3 and the ALU flags of rs1 - rs2.
  always_comb begin
    taken_s = 1'b0;
    case (func3)
      3'b000:  taken_s = zero;
      3'b001:  taken_s = ~zero;
      3'b100:  taken_s = neg;
      3'b101:  taken_s = ~neg;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state selection.
  always_comb begin
    next_state_s = ST_FETCH;
    case (state_r)
      ST_FETCH: next_state_s = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_R:               next_state_s = ST_EXE_R;
          OP_I:               next_state_s = ST_EXE_I;
          OP_LOAD, OP_STORE:  next_state_s = ST_MEM_ADR;
          OP_BRANCH:          next_state_s = ST_BRANCH;
          OP_JAL:             next_state_s = ST_JAL;
          OP_JALR:            next_state_s = ST_JALR;
          OP_LUI:             next_state_s = ST_LUI;
          default:            next_state_s = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_MEM_ADR: begin
        if (opcode == OP_LOAD) begin
          next_state_s = ST_MEM_RD;
        end else begin
          next_state_s = ST_MEM_WR;
        end
      end
      ST_MEM_RD:  next_state_s = ST_MEM_WB;
      ST_MEM_WB:  next_state_s = ST_FETCH;
      ST_MEM_WR:  next_state_s = ST_FETCH;
      ST_EXE_R:   next_state_s = ST_ALU_WB;
      ST_EXE_I:   next_state_s = ST_ALU_WB;
      ST_LUI:     next_state_s = ST_ALU_WB;
      ST_ALU_WB:  next_state_s = ST_FETCH;
      ST_BRANCH:  next_state_s = ST_FETCH;
      ST_JAL:     next_state_s = ST_ALU_WB;
      ST_JALR:    next_state_s = ST_JALR_PC;
      ST_JALR_PC: next_state_s = ST_ALU_WB;
      ST_HALT:    next_state_s = ST_HALT;
      default:    next_state_s = ST_FETCH;
    endcase
  end

  // Datapath controls decoded from the state; everything is forced low
  // while rst is high so an aborted instruction issues no further writes.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    AluSrcA    = 2'b00;
    AluSrcB    = 2'b00;
    AluOp      = ALUOP_ADD;
    ImmSrc     = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst) begin
      ImmSrc = 3'b000;
    end else begin
      ImmSrc = imm_src_s;
      case (state_r)
        ST_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          AluSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        ST_DECODE: begin
          AluSrcA = 2'b01;
          AluSrcB = 2'b01;
          case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI: illegal_op = 1'b0;
            default:                 illegal_op = 1'b1;
          endcase
        end
        ST_MEM_ADR, ST_JALR: begin
          AluSrcA = 2'b10;
          AluSrcB = 2'b01;
        end
        ST_MEM_RD: begin
          AdrSrc = 1'b1;
        end
        ST_MEM_WB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEM_WR: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        ST_EXE_R: begin
          AluSrcA = 2'b10;
          AluOp   = ALUOP_FUNC;
        end
        ST_EXE_I: begin
          AluSrcA = 2'b10;
          AluSrcB = 2'b01;
          AluOp   = ALUOP_FUNC;
        end
        ST_LUI: begin
          AluSrcA = 2'b11;
          AluSrcB = 2'b01;
        end
        ST_ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        ST_BRANCH: begin
          AluSrcA    = 2'b10;
          AluOp      = ALUOP_SUB;
          PCWrite    = taken_s;
          instr_done = 1'b1;
        end
        ST_JAL, ST_JALR_PC: begin
          AluSrcA = 2'b01;
          AluSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        ST_HALT: begin
          PCWrite = 1'b0;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle expected control
// vectors are queued when an instruction is driven and compared each cycle.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_h;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero;
  logic       neg;

  logic       pcw0, adr0, mw0, irw0, rw0, done0, ill0;
  logic [1:0] rs0, a0, b0, op0;
  logic [2:0] imm0;
  logic       pcw1, adr1, mw1, irw1, rw1, done1, ill1;
  logic [1:0] rs1, a1, b1, op1;
  logic [2:0] imm1;

  logic        use_h = 1'b0;
  logic [17:0] obs0, obs1, obs;
  logic [17:0] q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
    .ResultSrc(rs0), .AluSrcA(a0), .AluSrcB(b0), .AluOp(op0), .ImmSrc(imm0),
    .instr_done(done0), .illegal_op(ill0)
  );

  multi_cycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst_h), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
    .ResultSrc(rs1), .AluSrcA(a1), .AluSrcB(b1), .AluOp(op1), .ImmSrc(imm1),
    .instr_done(done1), .illegal_op(ill1)
  );

  assign obs0 = {pcw0, adr0, mw0, irw0, rw0, rs0, a0, b0, op0, imm0, done0, ill0};
  assign obs1 = {pcw1, adr1, mw1, irw1, rw1, rs1, a1, b1, op1, imm1, done1, ill1};
  assign obs  = use_h ? obs1 : obs0;

  // Vector layout: pcw adr mw irw rw rs[2] a[2] b[2] op[2] imm[3] done ill
  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [2:0] imm,
                                     input logic done, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, op, imm, done, ill};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (pcw adr mw irw rw rs a b op imm done ill)",
               tag, got, exp);
    end
  endtask

  // Compare one cycle at the negedge, then advance to just after the next posedge.
  task automatic step(input string tag);
    logic [17:0] e;
    @(negedge clk);
    e = q.pop_front();
    check_eq(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (q.size() > 0 && guard < 32) begin
      step(tag);
      guard++;
    end
  endtask

  task automatic push_fetch_decode(input logic [6:0] o, input logic ill);
    logic [2:0] im;
    im = exp_imm(o);
    q.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,im,1'b0,1'b0));
    q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,im,1'b0,ill));
  endtask

  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input logic n);
    logic [2:0] im;
    logic [17:0] wb;
    opcode = o; func3 = f3; zero = z; neg = n;
    im = exp_imm(o);
    wb = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,im,1'b1,1'b0);
    case (o)
      7'b0110011: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,im,1'b0,1'b0));
        q.push_back(wb);
      end
      7'b0010011: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,im,1'b0,1'b0));
        q.push_back(wb);
      end
      7'b0110111: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b01,2'b00,im,1'b0,1'b0));
        q.push_back(wb);
      end
      7'b0000011: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,im,1'b0,1'b0));
        q.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,im,1'b0,1'b0));
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,im,1'b1,1'b0));
      end
      7'b0100011: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,im,1'b0,1'b0));
        q.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,im,1'b1,1'b0));
      end
      7'b1100011: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(exp_taken(f3,z,n),1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,im,1'b1,1'b0));
      end
      7'b1101111: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,im,1'b0,1'b0));
        q.push_back(wb);
      end
      7'b1100111: begin
        push_fetch_decode(o, 1'b0);
        q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,im,1'b0,1'b0));
        q.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,im,1'b0,1'b0));
        q.push_back(wb);
      end
      default: begin
        push_fetch_decode(o, 1'b1);
      end
    endcase
    drain(tag);
  endtask

  initial begin
    logic [17:0] zv;
    zv = 18'd0;
    rst = 1'b1; rst_h = 1'b1;
    opcode = 7'b0110011; func3 = 3'b000; zero = 1'b0; neg = 1'b0;
    @(posedge clk); #1;
    // Reset held for two cycles: no enables, no selects.
    q.push_back(zv); q.push_back(zv);
    drain("reset");
    rst = 1'b0;

    run_instr("add",      7'b0110011, 3'b000, 1'b0, 1'b0);
    run_instr("addi",     7'b0010011, 3'b000, 1'b0, 1'b0);
    run_instr("lui",      7'b0110111, 3'b000, 1'b0, 1'b0);
    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0);
    run_instr("beq_tk",   7'b1100011, 3'b000, 1'b1, 1'b0);
    run_instr("beq_nt",   7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr("bne_tk",   7'b1100011, 3'b001, 1'b0, 1'b0);
    run_instr("bne_nt",   7'b1100011, 3'b001, 1'b1, 1'b0);
    run_instr("blt_tk",   7'b1100011, 3'b100, 1'b0, 1'b1);
    run_instr("bge_tk",   7'b1100011, 3'b101, 1'b0, 1'b0);
    run_instr("bge_nt",   7'b1100011, 3'b101, 1'b0, 1'b1);
    run_instr("f3_010",   7'b1100011, 3'b010, 1'b1, 1'b1);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0);
    run_instr("jalr",     7'b1100111, 3'b000, 1'b0, 1'b0);
    run_instr("illegal",  7'b0000000, 3'b000, 1'b0, 1'b0);
    run_instr("add_after_ill", 7'b0110011, 3'b000, 1'b0, 1'b0);

    // Reset raised while in MEM_WR: the store strobe must never appear.
    opcode = 7'b0100011; func3 = 3'b010;
    push_fetch_decode(7'b0100011, 1'b0);
    q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,3'b001,1'b0,1'b0));
    drain("sw_abort_pre");
    rst = 1'b1;
    q.push_back(zv);
    drain("sw_abort_rst");
    rst = 1'b0;
    run_instr("lw_after_abort", 7'b0000011, 3'b010, 1'b0, 1'b0);

    // ILLEGAL_HALT=1 instance: illegal opcode parks the FSM until reset.
    use_h = 1'b1;
    opcode = 7'b0000000;
    rst_h = 1'b0;
    push_fetch_decode(7'b0000000, 1'b1);
    for (int i = 0; i < 4; i++) q.push_back(zv);
    drain("halt");
    opcode = 7'b0110011;
    drain("halt_opchg");
    q.push_back(zv);
    drain("halt_opchg");
    rst_h = 1'b1;
    q.push_back(zv);
    drain("halt_rst");
    rst_h = 1'b0;
    run_instr("halt_add", 7'b0110011, 3'b000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
